// File: rtl/ir_receiver_mc.sv
// Multi-channel pulse-width IR frame receiver. Each channel decodes start/data
// low times into a frame, checks the 10..10 framing, and hands accepted frames
// through a per-channel holding register into a shared APB-readable FIFO.
module ir_receiver_mc #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 11,
    parameter int START_MIN  = 85000,
    parameter int START_MAX  = 115000,
    parameter int ONE_MIN    = 40000,
    parameter int TIMEOUT    = 200000,
    parameter int HOLDOFF    = 15000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NUM_CH-1:0] ir_recv,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] GOT_HIT,
    output logic              IRQ
);
    // Counters must reach past every threshold so all-ones always reads as "too long".
    localparam int M1   = (START_MAX > TIMEOUT) ? START_MAX : TIMEOUT;
    localparam int MAXV = (M1 > HOLDOFF) ? M1 : HOLDOFF;
    localparam int CW   = $clog2(MAXV + 2);
    localparam int IW   = $clog2(FRAME_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = 18;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_HOLD} state_e;

    logic [NUM_CH-1:0]     sync1_q, sync2_q, prev_q;
    logic [CW-1:0]         lo_q   [NUM_CH];
    logic [CW-1:0]         hi_q   [NUM_CH];
    logic [IW-1:0]         idx_q  [NUM_CH];
    logic [FRAME_BITS-1:0] shf_q  [NUM_CH];
    state_e                st_q   [NUM_CH];
    state_e                st_d   [NUM_CH];
    logic [NUM_CH-1:0]     hv_q;
    logic [FRAME_BITS-1:0] hd_q   [NUM_CH];
    logic [NUM_CH-1:0]     got_q;
    logic [NUM_CH-1:0]     ctrl_q;
    logic                  ovf_q;
    logic [EW-1:0]         mem    [FIFO_DEPTH];
    logic [AW:0]           wp_q, rp_q;

    logic [NUM_CH-1:0]     rise, tout, bit_one, start_ok, hold_done;
    logic [NUM_CH-1:0]     accept, drop_occ, gnt;
    logic [FRAME_BITS-1:0] frame_c [NUM_CH];
    logic [1:0]            gnt_id;
    logic [FRAME_BITS-1:0] gnt_data;
    logic [EW-1:0]         ent;
    logic                  wr_en, pop, push, push_ok, drop_full, empty, full, ovf_set, ovf_clr;
    logic [AW:0]           level;
    logic                  unused_pwdata;

    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        frame_ok = (f[FRAME_BITS-1:FRAME_BITS-2] == 2'b10) && (f[1:0] == 2'b10);
    endfunction

    // Per-channel timing decode of the synchronized line.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rise[c]      = sync2_q[c] & ~prev_q[c];
            tout[c]      = (lo_q[c] > CW'(TIMEOUT)) || (hi_q[c] > CW'(TIMEOUT));
            bit_one[c]   = lo_q[c] >= CW'(ONE_MIN);
            start_ok[c]  = (lo_q[c] > CW'(START_MIN)) && (lo_q[c] < CW'(START_MAX));
            hold_done[c] = hi_q[c] == CW'(HOLDOFF - 1);
            frame_c[c]   = {shf_q[c][FRAME_BITS-2:0], bit_one[c]};
        end
    end

    // Per-channel FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (PRESET) st_q[c] <= ST_IDLE;
            else        st_q[c] <= st_d[c];
        end
    end

    // Per-channel next-state logic.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c] = st_q[c];
            if (!ctrl_q[c]) begin
                st_d[c] = ST_IDLE;
            end else begin
                case (st_q[c])
                    ST_IDLE: if (rise[c] && start_ok[c]) st_d[c] = ST_DATA;
                    ST_DATA: begin
                        if (tout[c]) st_d[c] = ST_IDLE;
                        else if (rise[c] && idx_q[c] == '0)
                            st_d[c] = frame_ok(frame_c[c]) ? ST_HOLD : ST_IDLE;
                    end
                    ST_HOLD: if (hold_done[c]) st_d[c] = ST_IDLE;
                    default: st_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    // FSM outputs: frame acceptance/drop and fixed-priority FIFO grant (lowest channel wins).
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        gnt_data = '0;
        accept   = '0;
        drop_occ = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_q[c] && st_q[c] == ST_DATA && !tout[c] && rise[c] &&
                idx_q[c] == '0 && frame_ok(frame_c[c])) begin
                accept[c]   = ~hv_q[c];
                drop_occ[c] = hv_q[c];
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hv_q[c]) begin
                gnt      = '0;
                gnt[c]   = 1'b1;
                gnt_id   = 2'(c);
                gnt_data = hd_q[c];
            end
        end
    end

    // Synchronizers, saturating level counters and the bit shift register.
    // During HOLD the low counter is pinned at all-ones so a pulse that
    // straddles the HOLD exit can never look like a valid start.
    always_ff @(posedge PCLK or posedge PRESET) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (PRESET) begin
                sync1_q[c] <= 1'b1;
                sync2_q[c] <= 1'b1;
                prev_q[c]  <= 1'b1;
                lo_q[c]    <= '0;
                hi_q[c]    <= '0;
                idx_q[c]   <= IW'(FRAME_BITS - 1);
                shf_q[c]   <= '0;
            end else begin
                sync1_q[c] <= ir_recv[c];
                sync2_q[c] <= sync1_q[c];
                prev_q[c]  <= sync2_q[c];
                if (!ctrl_q[c]) begin
                    lo_q[c]  <= '0;
                    hi_q[c]  <= '0;
                    idx_q[c] <= IW'(FRAME_BITS - 1);
                    shf_q[c] <= '0;
                end else if (st_q[c] == ST_HOLD) begin
                    lo_q[c] <= '1;
                    hi_q[c] <= hold_done[c] ? '0 : hi_q[c] + 1'b1;
                end else begin
                    lo_q[c] <= sync2_q[c] ? '0 : (&lo_q[c] ? lo_q[c] : lo_q[c] + 1'b1);
                    hi_q[c] <= (!sync2_q[c] || st_d[c] == ST_HOLD) ? '0 :
                               (&hi_q[c] ? hi_q[c] : hi_q[c] + 1'b1);
                    if (st_q[c] == ST_IDLE) begin
                        idx_q[c] <= IW'(FRAME_BITS - 1);
                        shf_q[c] <= '0;
                    end else if (rise[c]) begin
                        idx_q[c] <= idx_q[c] - 1'b1;
                        shf_q[c] <= frame_c[c];
                    end
                end
            end
        end
    end

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign empty     = (wp_q == rp_q);
    assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign level     = wp_q - rp_q;
    assign pop       = PSEL & PENABLE & ~PWRITE & (PADDR == 8'h08) & ~empty;
    assign push      = |hv_q;
    assign push_ok   = push & (~full | pop);
    assign drop_full = push & full & ~pop;
    assign ovf_set   = drop_full | (|drop_occ);
    assign ovf_clr   = wr_en & (PADDR == 8'h04) & PWDATA[2];
    assign ent       = {gnt_id, 16'(gnt_data)};

    // Holding registers, GOT_HIT pulses, FIFO pointers, CTRL and sticky OVF.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            hv_q   <= '0;
            got_q  <= '0;
            ctrl_q <= '1;
            ovf_q  <= 1'b0;
            wp_q   <= '0;
            rp_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) hd_q[c] <= '0;
        end else begin
            got_q <= accept;
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    hv_q[c] <= 1'b1;
                    hd_q[c] <= frame_c[c];
                end else if (gnt[c]) begin
                    hv_q[c] <= 1'b0;
                end
            end
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop)     rp_q <= rp_q + 1'b1;
            if (wr_en && PADDR == 8'h00) ctrl_q <= PWDATA[NUM_CH-1:0];
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // FIFO storage.
    always_ff @(posedge PCLK) begin
        if (push_ok) mem[wp_q[AW-1:0]] <= ent;
    end

    // APB read mux.
    always_comb begin
        PRDATA = '0;
        case (PADDR)
            8'h00: PRDATA[NUM_CH-1:0] = ctrl_q;
            8'h04: begin
                PRDATA[0]   = empty;
                PRDATA[1]   = full;
                PRDATA[2]   = ovf_q;
                PRDATA[8:4] = 5'(level);
            end
            8'h08: if (!empty) PRDATA = {1'b1, 13'b0, mem[rp_q[AW-1:0]]};
            default: PRDATA = '0;
        endcase
    end

    assign PREADY        = 1'b1;
    assign PSLVERR       = 1'b0;
    assign GOT_HIT       = got_q;
    assign IRQ           = ~empty;
    assign unused_pwdata = ^PWDATA;
endmodule
